// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and FSM state type for the serial CLA adder
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum of products of P/G and cin, no rippling.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// rtl/cla_serial_add_ctrl.sv - WIDTH-bit add/subtract streamed nibble-serially through one CLA slice
module cla_serial_add_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NNIB);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   nib_s;
    logic               nib_c;
    logic               accept;
    logic               last_nib;

    assign nib_a    = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_b    = b_q[idx_q*NIB_W +: NIB_W];
    assign last_nib = (idx_q == IDX_W'(NNIB - 1));
    assign accept   = in_valid && in_ready;

    cla4_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Subtract is folded in at accept time: B is stored inverted and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub | cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q*NIB_W +: NIB_W] <= nib_s;
            carry_q <= nib_c;
            if (last_nib) begin
                idx_q  <= '0;
                cout_q <= nib_c;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIB_W-1] != a_q[WIDTH-1]);
            end else begin
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb/tb_cla_serial_add_ctrl.sv - scoreboard bench for the nibble-serial CLA adder
module tb_cla_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cla_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic msub);
        exp_t        e;
        logic [16:0] full;
        if (msub) begin
            full = {1'b0, ma} - {1'b0, mb};
            e.cout = (ma >= mb);
            e.ovf  = (ma[15] != mb[15]) && (full[15] != ma[15]);
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
            e.cout = full[16];
            e.ovf  = (ma[15] == mb[15]) && (full[15] != ma[15]);
        end
        e.sum = full[15:0];
        return e;
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                          input logic tsub, input exp_t e, input int stall);
        int   k;
        exp_t got;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; op_sub = tsub; in_valid = 1'b1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
        check("busy_run", {31'd0, busy}, 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        check("latency", k, 32'd5);
        got = sb.pop_front();
        check("sum", {16'd0, sum}, {16'd0, got.sum});
        check("cout", {31'd0, cout}, {31'd0, got.cout});
        check("ovf", {31'd0, ovf}, {31'd0, got.ovf});
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_sum", {16'd0, sum}, {16'd0, got.sum});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        exp_t e;
        logic seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic rc;
        logic rs;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        e = '{16'h5555, 1'b0, 1'b0}; run_op(16'h1234, 16'h4321, 1'b0, 1'b0, e, 0);
        e = '{16'h0000, 1'b1, 1'b0}; run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, e, 0);
        e = '{16'h8000, 1'b0, 1'b1}; run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, e, 0);
        e = '{16'h7FFF, 1'b1, 1'b1}; run_op(16'h8000, 16'h0001, 1'b0, 1'b1, e, 0);
        e = '{16'hFFFE, 1'b0, 1'b0}; run_op(16'h0003, 16'h0005, 1'b1, 1'b1, e, 0);
        e = '{16'h0BEF, 1'b0, 1'b0}; run_op(16'h0ABC, 16'h0132, 1'b1, 1'b0, e, 3);

        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_stale_result", {31'd0, seen}, 32'd0);
        e = '{16'h0002, 1'b0, 1'b0}; run_op(16'h0001, 16'h0001, 1'b0, 1'b0, e, 0);

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), i % 2);
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
